// File: rtl/accel_tilt_filter.sv
`default_nettype none
// ============================================================================
//  Module   : accel_tilt_filter
//  Purpose  : Block-averages signed 12-bit accelerometer X/Y samples, applies a
//             deadzone, and integrates tilt once per VGA frame into one-cycle
//             ball move strobes.  Define TILT_INVERT_EN for 180-degree-mounted
//             boards (both axes negated at the input, -2048 saturates to 2047).
//  Revision : 1.0  initial release
// ============================================================================
module accel_tilt_filter #(
    parameter int AVG_LOG2    = 3,
    parameter int DEADZONE    = 64,
    parameter int SPEED_SHIFT = 6
) (
    input  logic        vgaclk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] x_raw,
    input  logic [11:0] y_raw,
    input  logic        frame_tick,
    output logic [11:0] tilt_x,
    output logic [11:0] tilt_y,
    output logic        tilt_valid,
    output logic        move_right,
    output logic        move_left,
    output logic        move_down,
    output logic        move_up
);
    localparam int                 SW    = 12 + AVG_LOG2;
    localparam logic signed [12:0] c_DZ  = 13'(DEADZONE);
    localparam logic signed [15:0] c_T   = 16'(2 ** SPEED_SHIFT);
    localparam logic signed [15:0] c_TM1 = c_T - 16'sd1;

    logic [11:0] w_x_in;
    logic [11:0] w_y_in;

`ifdef TILT_INVERT_EN
    assign w_x_in = (x_raw == 12'h800) ? 12'h7FF : (~x_raw + 12'd1);
    assign w_y_in = (y_raw == 12'h800) ? 12'h7FF : (~y_raw + 12'd1);
`else
    assign w_x_in = x_raw;
    assign w_y_in = y_raw;
`endif

    // ---------------- accumulation ----------------
    logic signed [SW-1:0]  r_sum_x, r_sum_y;
    logic signed [SW-1:0]  w_nsum_x, w_nsum_y;
    logic [AVG_LOG2-1:0]   r_cnt;
    logic [11:0]           r_hold_x, r_hold_y;
    logic                  r_hold_vld;

    assign w_nsum_x = r_sum_x + {{AVG_LOG2{w_x_in[11]}}, w_x_in};
    assign w_nsum_y = r_sum_y + {{AVG_LOG2{w_y_in[11]}}, w_y_in};

    // The hold registers keep only the upper bits: dropping the low AVG_LOG2
    // bits of a two's-complement sum is exactly the floor division.
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_cnt      <= '0;
            r_hold_x   <= '0;
            r_hold_y   <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            r_hold_vld <= 1'b0;
            if (sample_valid) begin
                if (&r_cnt) begin
                    r_hold_x   <= w_nsum_x[SW-1:AVG_LOG2];
                    r_hold_y   <= w_nsum_y[SW-1:AVG_LOG2];
                    r_hold_vld <= 1'b1;
                    r_sum_x    <= '0;
                    r_sum_y    <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_sum_x <= w_nsum_x;
                    r_sum_y <= w_nsum_y;
                    r_cnt   <= r_cnt + AVG_LOG2'(1);
                end
            end
        end
    end

    // ---------------- averaged output ----------------
    always_ff @(posedge vgaclk) begin
        if (reset) begin
            tilt_x     <= '0;
            tilt_y     <= '0;
            tilt_valid <= 1'b0;
        end else begin
            tilt_valid <= r_hold_vld;
            if (r_hold_vld) begin
                tilt_x <= r_hold_x;
                tilt_y <= r_hold_y;
            end
        end
    end

    // ---------------- deadzone ----------------
    function automatic logic signed [12:0] deadzone(input logic [11:0] a);
        logic signed [12:0] v;
        v = {a[11], a};
        if (v > c_DZ)
            return v - c_DZ;
        else if (v < -c_DZ)
            return v + c_DZ;
        return 13'sd0;
    endfunction

    logic signed [12:0] r_eff_x, r_eff_y;

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            r_eff_x <= '0;
            r_eff_y <= '0;
        end else if (tilt_valid) begin
            r_eff_x <= deadzone(tilt_x);
            r_eff_y <= deadzone(tilt_y);
        end
    end

    // ---------------- frame integration ----------------
    logic signed [13:0] r_frac_x, r_frac_y;
    logic signed [15:0] w_fx, w_fy;

    assign w_fx = {{2{r_frac_x[13]}}, r_frac_x} + {{3{r_eff_x[12]}}, r_eff_x};
    assign w_fy = {{2{r_frac_y[13]}}, r_frac_y} + {{3{r_eff_y[12]}}, r_eff_y};

    // Residue is clamped inside +/-(T-1) so large tilt cannot wind up.
    function automatic logic signed [13:0] next_frac(input logic signed [15:0] f);
        if (f >= c_T)
            return 14'(((f - c_T) > c_TM1) ? c_TM1 : (f - c_T));
        else if (f <= -c_T)
            return 14'(((f + c_T) < -c_TM1) ? -c_TM1 : (f + c_T));
        return 14'(f);
    endfunction

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            r_frac_x   <= '0;
            r_frac_y   <= '0;
            move_right <= 1'b0;
            move_left  <= 1'b0;
            move_down  <= 1'b0;
            move_up    <= 1'b0;
        end else begin
            move_right <= 1'b0;
            move_left  <= 1'b0;
            move_down  <= 1'b0;
            move_up    <= 1'b0;
            if (frame_tick) begin
                r_frac_x   <= next_frac(w_fx);
                r_frac_y   <= next_frac(w_fy);
                move_right <= (w_fx >= c_T);
                move_left  <= (w_fx <= -c_T);
                move_down  <= (w_fy >= c_T);
                move_up    <= (w_fy <= -c_T);
            end
        end
    end

endmodule
`default_nettype wire
